retire_trace_monitor: RTL

- Synthesizable, parametrised successor to the CPU bench trace logger.
- Sits beside the pipelined CPU. Takes one retirement event per cycle from the writeback stage and classifies it the way the bench trace does: reg-write, load, store, nop/branch or halt.
- Stamps each event with an instruction number. Buffers the records in a FIFO that the bench or a debug port drains with a valid/ready handshake.
- Also keeps cycle and instruction counters, latches halt, and fires a watchdog timeout.

---
 rtl/retire_trace_monitor.sv | 116 +++++++++++
 1 files changed

// File: rtl/retire_trace_monitor.sv
// retire_trace_monitor: classifies CPU retirements, numbers them, queues records in a FWFT FIFO, tracks cycle/inst counters, halt and watchdog timeout
module retire_trace_monitor #(
  parameter int XLEN        = 16,
  parameter int REG_W       = 4,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       ret_valid,
  input  logic [XLEN-1:0]            ret_pc,
  input  logic [XLEN-1:0]            ret_inst,
  input  logic                       ret_reg_we,
  input  logic [REG_W-1:0]           ret_reg,
  input  logic [XLEN-1:0]            ret_reg_data,
  input  logic                       ret_mem_rd,
  input  logic                       ret_mem_we,
  input  logic [XLEN-1:0]            ret_mem_addr,
  input  logic [XLEN-1:0]            ret_mem_data,
  input  logic                       ret_halt,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [2:0]                 rec_kind,
  output logic [CNT_W-1:0]           rec_inum,
  output logic [XLEN-1:0]            rec_pc,
  output logic [REG_W-1:0]           rec_reg,
  output logic [XLEN-1:0]            rec_addr,
  output logic [XLEN-1:0]            rec_value,
  output logic [CNT_W-1:0]           inst_count,
  output logic [CNT_W-1:0]           cycle_count,
  output logic                       halted,
  output logic                       timeout,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);
  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 3 + CNT_W + 3 * XLEN + REG_W;
  localparam logic [2:0] K_REG = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2, K_NOP = 3'd3, K_HALT = 3'd4, K_TIMEOUT = 3'd5;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      lvl_q, lvl_d;
  logic [CNT_W-1:0] inst_q, inst_d, cyc_q, cyc_d, drop_q, drop_d;
  logic             halted_q, halted_d, timeout_q, timeout_d, pend_q, pend_d, ovf_q, ovf_d;
  logic             acc, pop, space, push, is_rl, is_mem, cyc_step, fire;
  logic [2:0]       kind;
  logic [REC_W-1:0] wdata, head;
  logic             unused_inst;
  assign unused_inst = ^ret_inst;
  always_comb begin
    acc       = enable & ret_valid & ~halted_q & ~timeout_q;
    kind      = ret_reg_we ? (ret_mem_rd ? K_LOAD : K_REG) : ret_halt ? K_HALT : ret_mem_we ? K_STORE : K_NOP;
    is_rl     = ret_reg_we;
    is_mem    = ret_reg_we ? ret_mem_rd : (~ret_halt & ret_mem_we);
    rec_valid = lvl_q != '0;
    pop       = rec_valid & rec_ready;
    space     = (lvl_q != (AW+1)'(DEPTH)) | pop;
    // a retirement always owns the push slot; the timeout record waits for a free one
    push      = acc ? space : (pend_q & space);
    wdata     = acc ? {kind, inst_q, ret_pc, is_rl ? ret_reg : {REG_W{1'b0}},
                       is_mem ? ret_mem_addr : {XLEN{1'b0}},
                       is_rl ? ret_reg_data : (kind == K_STORE) ? ret_mem_data : {XLEN{1'b0}}}
                    : {K_TIMEOUT, inst_q, {(3*XLEN+REG_W){1'b0}}};
    wp_d      = wp_q + AW'(push);
    rp_d      = rp_q + AW'(pop);
    lvl_d     = lvl_q + (AW+1)'(push) - (AW+1)'(pop);
    inst_d    = inst_q + CNT_W'(acc & (inst_q != '1));
    drop_d    = drop_q + CNT_W'(acc & ~space & (drop_q != '1));
    ovf_d     = ovf_q | (acc & ~space);
    halted_d  = halted_q | (acc & (kind == K_HALT));
    cyc_step  = enable & ~halted_q & ~timeout_q & (cyc_q != '1);
    cyc_d     = cyc_q + CNT_W'(cyc_step);
    fire      = cyc_step & (cyc_d == CNT_W'(CYCLE_LIMIT));
    timeout_d = timeout_q | fire;
    pend_d    = fire | (pend_q & ~(~acc & space));
    head      = mem_q[rp_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      lvl_q     <= '0;
      inst_q    <= '0;
      cyc_q     <= '0;
      drop_q    <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      lvl_q     <= lvl_d;
      inst_q    <= inst_d;
      cyc_q     <= cyc_d;
      drop_q    <= drop_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wdata;
  end
  assign {rec_kind, rec_inum, rec_pc, rec_reg, rec_addr, rec_value} = rec_valid ? head : '0;
  assign inst_count  = inst_q;
  assign cycle_count = cyc_q;
  assign drop_count  = drop_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign overflow    = ovf_q;
  assign fifo_level  = lvl_q;
endmodule
